// File: rtl/deit_feeder.sv
// ---------------------------------------------------------------------------
// deit_feeder
//
// Feeds a systolic core with weight and activation vectors. Each side has its
// own buffer with one write port and one read port. The core pulls
// vectors one at a time through its ctrl enables. Each read pointer wraps at
// a programmable pass length, and the last read of every pass is flagged with
// a one-cycle pass_done pulse.
//
// Ports
//   clk, rst_n                  : clock (rising edge), synchronous active-low reset
//   wr_act_en/addr/data         : activation buffer write port
//   wr_wgt_en/addr/data         : weight buffer write port
//   cfg_act_len, cfg_wgt_len    : vectors per pass (0 or > depth = full depth)
//   rewind                      : clear both read pointers, no read this edge
//   ctrl_weight_load_en         : core takes the next weight vector
//   ctrl_input_stream_en        : core takes the next activation vector
//   in_weight_vec               : weight vector, held between loads
//   in_act_vec                  : activation vector, zero when not streaming
//   act_pass_done/wgt_pass_done : pulse with the last vector of a pass
//   busy                        : a pass is partially consumed on either side
// ---------------------------------------------------------------------------
module deit_feeder #(
  parameter int ARRAY_ROW  = 12,
  parameter int ARRAY_COL  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACT_DEPTH  = 64,
  parameter int WGT_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_act_en,
  input  logic [$clog2(ACT_DEPTH)-1:0]    wr_act_addr,
  input  logic [ARRAY_ROW*DATA_WIDTH-1:0] wr_act_data,
  input  logic                            wr_wgt_en,
  input  logic [$clog2(WGT_DEPTH)-1:0]    wr_wgt_addr,
  input  logic [ARRAY_COL*DATA_WIDTH-1:0] wr_wgt_data,
  input  logic [$clog2(ACT_DEPTH):0]      cfg_act_len,
  input  logic [$clog2(WGT_DEPTH):0]      cfg_wgt_len,
  input  logic                            rewind,
  input  logic                            ctrl_weight_load_en,
  input  logic                            ctrl_input_stream_en,
  output logic [ARRAY_COL*DATA_WIDTH-1:0] in_weight_vec,
  output logic [ARRAY_ROW*DATA_WIDTH-1:0] in_act_vec,
  output logic                            act_pass_done,
  output logic                            wgt_pass_done,
  output logic                            busy
);

  localparam int AW = $clog2(ACT_DEPTH);
  localparam int WW = $clog2(WGT_DEPTH);
  localparam int AVW = ARRAY_ROW * DATA_WIDTH;
  localparam int WVW = ARRAY_COL * DATA_WIDTH;

  localparam logic [AW:0] ACT_DEPTH_L = (AW+1)'(ACT_DEPTH);
  localparam logic [WW:0] WGT_DEPTH_L = (WW+1)'(WGT_DEPTH);

  // Buffers
  logic [AVW-1:0] act_mem [ACT_DEPTH];
  logic [WVW-1:0] wgt_mem [WGT_DEPTH];

  // NOTE: buffer arrays have no reset; clearing them would turn the RAMs into
  // flop arrays, and their contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (wr_act_en) act_mem[wr_act_addr] <= wr_act_data;
    if (wr_wgt_en) wgt_mem[wr_wgt_addr] <= wr_wgt_data;
  end

  // State
  logic [AW-1:0]  aptr_q, aptr_d;
  logic [WW-1:0]  wptr_q, wptr_d;
  logic [AVW-1:0] in_act_vec_q, in_act_vec_d;
  logic [WVW-1:0] in_weight_vec_q, in_weight_vec_d;
  logic           act_pass_done_q, act_pass_done_d;
  logic           wgt_pass_done_q, wgt_pass_done_d;
  logic           busy_q, busy_d;

  // Next-state logic
  logic [AW:0]   act_len_eff;
  logic [WW:0]   wgt_len_eff;
  logic [AW-1:0] act_last;
  logic [WW-1:0] wgt_last;
  logic          act_rd_en, wgt_rd_en;
  logic          act_at_last, wgt_at_last;

  // NOTE: every signal assigned here gets a value on every path (defaults
  // first), so no latches are inferred.
  always_comb begin
    // A zero or oversized length means "use the whole buffer".
    act_len_eff = (cfg_act_len == '0 || cfg_act_len > ACT_DEPTH_L) ? ACT_DEPTH_L : cfg_act_len;
    wgt_len_eff = (cfg_wgt_len == '0 || cfg_wgt_len > WGT_DEPTH_L) ? WGT_DEPTH_L : cfg_wgt_len;
    act_last    = AW'(act_len_eff - 1'b1);
    wgt_last    = WW'(wgt_len_eff - 1'b1);

    // Rewind wins over both read requests: nothing is read and nothing advances.
    act_rd_en   = ctrl_input_stream_en & ~rewind;
    wgt_rd_en   = ctrl_weight_load_en & ~rewind;
    act_at_last = (aptr_q == act_last);
    wgt_at_last = (wptr_q == wgt_last);

    aptr_d = aptr_q;
    if (rewind)         aptr_d = '0;
    else if (act_rd_en) aptr_d = act_at_last ? '0 : aptr_q + 1'b1;

    wptr_d = wptr_q;
    if (rewind)         wptr_d = '0;
    else if (wgt_rd_en) wptr_d = wgt_at_last ? '0 : wptr_q + 1'b1;

    // The read uses the array contents before this edge's write lands, so a
    // same-address write shows up on the following read.
    in_act_vec_d    = act_rd_en ? act_mem[aptr_q] : '0;
    in_weight_vec_d = wgt_rd_en ? wgt_mem[wptr_q] : in_weight_vec_q;

    act_pass_done_d = act_rd_en & act_at_last;
    wgt_pass_done_d = wgt_rd_en & wgt_at_last;

    // Computed from the next pointers so busy lines up with the pointer flops.
    busy_d = (aptr_d != '0) || (wptr_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aptr_q          <= '0;
      wptr_q          <= '0;
      in_act_vec_q    <= '0;
      in_weight_vec_q <= '0;
      act_pass_done_q <= 1'b0;
      wgt_pass_done_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      aptr_q          <= aptr_d;
      wptr_q          <= wptr_d;
      in_act_vec_q    <= in_act_vec_d;
      in_weight_vec_q <= in_weight_vec_d;
      act_pass_done_q <= act_pass_done_d;
      wgt_pass_done_q <= wgt_pass_done_d;
      busy_q          <= busy_d;
    end
  end

  assign in_act_vec    = in_act_vec_q;
  assign in_weight_vec = in_weight_vec_q;
  assign act_pass_done = act_pass_done_q;
  assign wgt_pass_done = wgt_pass_done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_deit_feeder.sv
// ---------------------------------------------------------------------------
// tb_deit_feeder
//
// Scoreboard bench for deit_feeder. The stimulus process drives one cycle at a
// time and, after each rising edge, asks a behavioural model what the outputs
// must be. It pushes that expectation into a queue. A monitor process pops one
// expectation per falling edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_deit_feeder;

  localparam int AR  = 12;
  localparam int AC  = 16;
  localparam int DW  = 8;
  localparam int AD  = 64;
  localparam int WD  = 16;
  localparam int AAW = $clog2(AD);
  localparam int WAW = $clog2(WD);
  localparam int AVW = AR * DW;
  localparam int WVW = AC * DW;

  logic           clk;
  logic           rst_n;
  logic           wr_act_en;
  logic [AAW-1:0] wr_act_addr;
  logic [AVW-1:0] wr_act_data;
  logic           wr_wgt_en;
  logic [WAW-1:0] wr_wgt_addr;
  logic [WVW-1:0] wr_wgt_data;
  logic [AAW:0]   cfg_act_len;
  logic [WAW:0]   cfg_wgt_len;
  logic           rewind;
  logic           ctrl_weight_load_en;
  logic           ctrl_input_stream_en;
  logic [WVW-1:0] in_weight_vec;
  logic [AVW-1:0] in_act_vec;
  logic           act_pass_done;
  logic           wgt_pass_done;
  logic           busy;

  deit_feeder #(
    .ARRAY_ROW (AR),
    .ARRAY_COL (AC),
    .DATA_WIDTH(DW),
    .ACT_DEPTH (AD),
    .WGT_DEPTH (WD)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .wr_act_en           (wr_act_en),
    .wr_act_addr         (wr_act_addr),
    .wr_act_data         (wr_act_data),
    .wr_wgt_en           (wr_wgt_en),
    .wr_wgt_addr         (wr_wgt_addr),
    .wr_wgt_data         (wr_wgt_data),
    .cfg_act_len         (cfg_act_len),
    .cfg_wgt_len         (cfg_wgt_len),
    .rewind              (rewind),
    .ctrl_weight_load_en (ctrl_weight_load_en),
    .ctrl_input_stream_en(ctrl_input_stream_en),
    .in_weight_vec       (in_weight_vec),
    .in_act_vec          (in_act_vec),
    .act_pass_done       (act_pass_done),
    .wgt_pass_done       (wgt_pass_done),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  typedef struct packed {
    logic [AVW-1:0] act;
    logic [WVW-1:0] wgt;
    logic           act_done;
    logic           wgt_done;
    logic           busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   cycle    = 0;

  task automatic check(input string name, input logic [WVW-1:0] got,
                       input logic [WVW-1:0] exp, input int cyc);
    n_total++;
    if (got === exp) n_passed++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
  endtask

  initial begin : monitor
    exp_t e;
    int   c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("in_act_vec",    WVW'(in_act_vec),    WVW'(e.act),      c);
        check("in_weight_vec", in_weight_vec,       e.wgt,            c);
        check("act_pass_done", WVW'(act_pass_done), WVW'(e.act_done), c);
        check("wgt_pass_done", WVW'(wgt_pass_done), WVW'(e.wgt_done), c);
        check("busy",          WVW'(busy),          WVW'(e.busy),     c);
      end
    end
  end

  // Reference model: buffers as plain arrays, pointers as integers.
  logic [AVW-1:0] m_act [AD];
  logic [WVW-1:0] m_wgt [WD];
  int             m_ap = 0;
  int             m_wp = 0;
  exp_t           m_out = '0;

  function automatic int eff_len(input int len, input int depth);
    return (len == 0 || len > depth) ? depth : len;
  endfunction

  task automatic model_edge();
    int alen, wlen;
    alen = eff_len(int'(cfg_act_len), AD);
    wlen = eff_len(int'(cfg_wgt_len), WD);
    m_out.act_done = 1'b0;
    m_out.wgt_done = 1'b0;
    if (!rst_n) begin
      m_ap = 0;
      m_wp = 0;
      m_out.act = '0;
      m_out.wgt = '0;
    end else if (rewind) begin
      m_ap = 0;
      m_wp = 0;
      m_out.act = '0;
    end else begin
      if (ctrl_input_stream_en) begin
        m_out.act      = m_act[m_ap];
        m_out.act_done = (m_ap == alen - 1);
        m_ap           = (m_ap + 1) % alen;
      end else begin
        m_out.act = '0;
      end
      if (ctrl_weight_load_en) begin
        m_out.wgt      = m_wgt[m_wp];
        m_out.wgt_done = (m_wp == wlen - 1);
        m_wp           = (m_wp + 1) % wlen;
      end
    end
    m_out.busy = (m_ap != 0) || (m_wp != 0);
    // Writes land after the read above, giving old-data-on-collision.
    if (wr_act_en) m_act[wr_act_addr] = wr_act_data;
    if (wr_wgt_en) m_wgt[wr_wgt_addr] = wr_wgt_data;
  endtask

  // One clock cycle: inputs are already stable, the model evaluates at the
  // edge, then one-shot inputs are dropped after the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    exp_q.push_back(m_out);
    cyc_q.push_back(cycle);
    cycle++;
    @(negedge clk);
    wr_act_en = 1'b0;
    wr_wgt_en = 1'b0;
    rewind    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [AVW-1:0] rnd_act();
    logic [AVW-1:0] v;
    for (int i = 0; i < AVW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [WVW-1:0] rnd_wgt();
    logic [WVW-1:0] v;
    for (int i = 0; i < WVW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wr_act(input int addr, input logic [AVW-1:0] data);
    wr_act_en   = 1'b1;
    wr_act_addr = AAW'(addr);
    wr_act_data = data;
  endtask

  task automatic wr_wgt(input int addr, input logic [WVW-1:0] data);
    wr_wgt_en   = 1'b1;
    wr_wgt_addr = WAW'(addr);
    wr_wgt_data = data;
  endtask

  initial begin : stimulus
    logic [DW-1:0] lane;
    int            wait_cnt;

    rst_n = 1'b0;
    wr_act_en = 1'b0; wr_act_addr = '0; wr_act_data = '0;
    wr_wgt_en = 1'b0; wr_wgt_addr = '0; wr_wgt_data = '0;
    cfg_act_len = '0; cfg_wgt_len = '0;
    rewind = 1'b0;
    ctrl_weight_load_en = 1'b0;
    ctrl_input_stream_en = 1'b0;
    @(negedge clk);

    // Reset state
    ticks(2);
    rst_n = 1'b1;

    // Fill both buffers with random data
    for (int i = 0; i < AD; i++) begin
      wr_act(i, rnd_act());
      if (i < WD) wr_wgt(i, rnd_wgt());
      tick();
    end

    // Basic latency: lanes = index+1, 16-entry pass
    for (int i = 0; i < 16; i++) begin
      lane = DW'(i + 1);
      wr_act(i, {AR{lane}});
      tick();
    end
    cfg_act_len = 7'd16;
    ctrl_input_stream_en = 1'b1;
    ticks(16);
    ctrl_input_stream_en = 1'b0;
    ticks(2);

    // Weight hold and wrap: length 3, four loads with gaps
    cfg_wgt_len = 5'd3;
    wr_wgt(0, {AC{8'h0A}}); tick();
    wr_wgt(1, {AC{8'h0B}}); tick();
    wr_wgt(2, {AC{8'h0C}}); tick();
    for (int i = 0; i < 4; i++) begin
      ctrl_weight_load_en = 1'b1;
      tick();
      ctrl_weight_load_en = 1'b0;
      ticks(2);
    end
    rewind = 1'b1;
    tick();

    // Collision: overwrite entry 2 on the edge it is being read
    cfg_act_len = 7'd4;
    wr_act(2, {AR{8'h11}}); tick();
    ctrl_input_stream_en = 1'b1;
    ticks(2);
    wr_act(2, {AR{8'h55}});
    tick();
    ticks(4);
    ctrl_input_stream_en = 1'b0;
    tick();

    // Rewind together with stream enable at aptr=5
    cfg_act_len = 7'd16;
    ctrl_input_stream_en = 1'b1;
    ticks(5);
    rewind = 1'b1;
    tick();
    ticks(2);
    ctrl_input_stream_en = 1'b0;
    tick();
    rewind = 1'b1;
    tick();

    // Reset mid-pass at aptr=7, weights also partway through
    ctrl_input_stream_en = 1'b1;
    ctrl_weight_load_en  = 1'b1;
    ticks(7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(3);
    ctrl_input_stream_en = 1'b0;
    ctrl_weight_load_en  = 1'b0;
    tick();
    rewind = 1'b1;
    tick();

    // Length 0 -> full depth on activations, oversized length on weights
    cfg_act_len = 7'd0;
    cfg_wgt_len = 5'd20;
    ctrl_input_stream_en = 1'b1;
    ctrl_weight_load_en  = 1'b1;
    ticks(AD + 2);
    ctrl_input_stream_en = 1'b0;
    ctrl_weight_load_en  = 1'b0;
    rewind = 1'b1;
    tick();

    // Randomised traffic; lengths only change when pointers are being cleared
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) wr_act($urandom_range(0, AD - 1), rnd_act());
      if ($urandom_range(0, 2) == 0) wr_wgt($urandom_range(0, WD - 1), rnd_wgt());
      ctrl_input_stream_en = ($urandom_range(0, 3) != 0);
      ctrl_weight_load_en  = ($urandom_range(0, 1) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n || $urandom_range(0, 29) == 0) begin
        rewind      = 1'b1;
        cfg_act_len = 7'($urandom_range(0, 127));
        cfg_wgt_len = 5'($urandom_range(0, 31));
      end
      tick();
    end
    rst_n = 1'b1;
    ctrl_input_stream_en = 1'b0;
    ctrl_weight_load_en  = 1'b0;
    tick();

    // Drain the scoreboard, bounded
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0 pending", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
